// File: rtl/idexwb_fwd_pipe.sv
// Three-stage ID/EX/WB integer pipeline with a parametrised register file.
// Optional EX/WB-to-ID operand forwarding is enabled by defining IDEXWB_FWD_EN.

module idexwb_fwd_pipe_rf #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [WIDTH-1:0]         rdata1,
  output logic [WIDTH-1:0]         rdata2
);

  logic [WIDTH-1:0] RF [0:NREGS-1];

  // Register array: cleared on reset, one write port, r0 never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        RF[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      RF[waddr] <= wdata;
    end
  end

  // Asynchronous read ports; a same-cycle write is seen only after the edge.
  always_comb begin
    rdata1 = RF[raddr1];
    rdata2 = RF[raddr2];
  end

endmodule

module idexwb_fwd_pipe #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int IMMW  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               opcode,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [IMMW-1:0]          imm,
  output logic [WIDTH-1:0]         res,
  output logic [$clog2(NREGS)-1:0] rdout,
  output logic                     valid
);

  localparam int RW = $clog2(NREGS);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef struct packed {
    logic             v;
    logic [2:0]       op;
    logic [RW-1:0]    rd;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } id_ex_t;

  typedef struct packed {
    logic             v;
    logic [RW-1:0]    rd;
    logic [WIDTH-1:0] res;
  } ex_wb_t;

  id_ex_t           s1;
  ex_wb_t           s2;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] ex_res;
  logic [WIDTH-1:0] imm_sx;
  logic             issue;

  idexwb_fwd_pipe_rf #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) regs (
    .clk    (clk),
    .rst    (rst),
    .we     (s2.v),
    .waddr  (s2.rd),
    .wdata  (s2.res),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_a),
    .rdata2 (rf_b)
  );

  assign issue  = start && (opcode != OP_NOP);
  assign imm_sx = WIDTH'($signed(imm));

  // ID operand select: r0 is zero, then (optionally) in-flight results, then RF.
  always_comb begin
    opa = rf_a;
    opb = rf_b;
    if (rs1 == '0) begin
      opa = '0;
`ifdef IDEXWB_FWD_EN
    end else if (s1.v && (s1.rd == rs1)) begin
      opa = ex_res;
    end else if (s2.v && (s2.rd == rs1)) begin
      opa = s2.res;
`endif
    end
    if (rs2 == '0) begin
      opb = '0;
`ifdef IDEXWB_FWD_EN
    end else if (s1.v && (s1.rd == rs2)) begin
      opb = ex_res;
    end else if (s2.v && (s2.rd == rs2)) begin
      opb = s2.res;
`endif
    end
  end

  // EX: combinational ALU on the ID/EX register, wrapping modulo 2^WIDTH.
  always_comb begin
    ex_res = '0;
    unique case (s1.op)
      OP_ADD:  ex_res = s1.a + s1.b;
      OP_SUB:  ex_res = s1.a - s1.b;
      OP_MUL:  ex_res = WIDTH'($signed(s1.a) * $signed(s1.b));
      OP_ADDI: ex_res = s1.a + s1.imm;
      OP_AND:  ex_res = s1.a & s1.b;
      OP_OR:   ex_res = s1.a | s1.b;
      OP_XOR:  ex_res = s1.a ^ s1.b;
      default: ex_res = '0;
    endcase
  end

  // ID/EX register: capture decoded instruction or a cleared bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else if (issue) begin
      s1.v   <= 1'b1;
      s1.op  <= opcode;
      s1.rd  <= rd;
      s1.imm <= imm_sx;
      s1.a   <= opa;
      s1.b   <= opb;
    end else begin
      s1 <= '0;
    end
  end

  // EX/WB register: carries the result to the outputs and the RF write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= '0;
    end else if (s1.v) begin
      s2.v   <= 1'b1;
      s2.rd  <= s1.rd;
      s2.res <= ex_res;
    end else begin
      s2 <= '0;
    end
  end

  assign res   = s2.res;
  assign rdout = s2.rd;
  assign valid = s2.v;

endmodule

// File: tb/tb_idexwb_fwd_pipe.sv
// Directed bench for idexwb_fwd_pipe.
// Expected forwarding results follow IDEXWB_FWD_EN when it is defined.

module tb_idexwb_fwd_pipe;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] ADD  = 3'b001;
  localparam logic [2:0] MUL  = 3'b010;
  localparam logic [2:0] ADDI = 3'b011;
  localparam logic [2:0] SUB  = 3'b100;
  localparam logic [2:0] XOR_ = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [11:0] imm;
  logic [31:0] res;
  logic [4:0]  rdout;
  logic        valid;

  int n_cmp = 0;
  int n_bad = 0;

  idexwb_fwd_pipe dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .opcode (opcode),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd     (rd),
    .imm    (imm),
    .res    (res),
    .rdout  (rdout),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic st, input logic [2:0] op,
                      input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic [11:0] im);
    start  = st;
    opcode = op;
    rs1    = a;
    rs2    = b;
    rd     = d;
    imm    = im;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    step(1'b0, NOP, 5'd0, 5'd0, 5'd0, 12'd0);
  endtask

  task automatic single(input string tag, input logic [2:0] op,
                        input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic [11:0] im,
                        input logic [31:0] exp);
    step(1'b1, op, a, b, d, im);
    bubble();
    check({tag, "_res"}, res, exp);
    check({tag, "_rd"}, 32'(rdout), 32'(d));
    check({tag, "_v"}, 32'(valid), 32'd1);
    bubble();
    bubble();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bubble();
    rst = 1'b0;
  endtask

  logic [31:0] e8;
  logic [31:0] e9;
  logic [31:0] acc;

  initial begin
    rst = 1'b1;
    start = 1'b0; opcode = NOP;
    rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_rdout", 32'(rdout), 32'd0);
    check("rst_rf5", dut.regs.RF[5], 32'd0);
    rst = 1'b0;

    for (int i = 1; i <= 31; i++) begin
      step(1'b1, ADDI, 5'd0, 5'd0, 5'(i), 12'(i * 3));
      if (i > 1) begin
        check("fill_res", res, 32'((i - 1) * 3));
        check("fill_rd", 32'(rdout), 32'(i - 1));
        check("fill_v", 32'(valid), 32'd1);
      end
    end
    bubble();
    check("fill_last_res", res, 32'd93);
    check("fill_last_rd", 32'(rdout), 32'd31);
    repeat (3) bubble();
    check("fill_drain_v", 32'(valid), 32'd0);
    for (int i = 1; i <= 31; i++) begin
      check("fill_rf", dut.regs.RF[i], 32'(i * 3));
    end
    check("fill_rf0", dut.regs.RF[0], 32'd0);

    single("mul", MUL, 5'd1, 5'd2, 5'd3, 12'd0, 32'd18);
    single("sub", SUB, 5'd1, 5'd2, 5'd4, 12'd0, 32'hFFFF_FFFD);
    single("xor", XOR_, 5'd1, 5'd2, 5'd5, 12'd0, 32'd5);

    single("ld_m1", ADDI, 5'd0, 5'd0, 5'd10, 12'hFFF, 32'hFFFF_FFFF);
    single("ld_m2048", ADDI, 5'd0, 5'd0, 5'd11, 12'h800, 32'hFFFF_F800);
    single("sq", MUL, 5'd11, 5'd11, 5'd12, 12'd0, 32'h0040_0000);
    single("ld_512", ADDI, 5'd0, 5'd0, 5'd13, 12'd512, 32'h0000_0200);
    single("mk_min", MUL, 5'd12, 5'd13, 5'd12, 12'd0, 32'h8000_0000);
    single("mk_max", XOR_, 5'd12, 5'd10, 5'd14, 12'd0, 32'h7FFF_FFFF);
    single("ld_2", ADDI, 5'd0, 5'd0, 5'd15, 12'd2, 32'd2);
    single("mul_wrap", MUL, 5'd14, 5'd15, 5'd16, 12'd0, 32'hFFFF_FFFE);

    single("addi_r0", ADDI, 5'd0, 5'd0, 5'd0, 12'd5, 32'd5);
    check("r0_kept", dut.regs.RF[0], 32'd0);
    single("add_zero", ADD, 5'd0, 5'd0, 5'd6, 12'd0, 32'd0);
    check("rf6_zero", dut.regs.RF[6], 32'd0);

`ifdef IDEXWB_FWD_EN
    e8 = 32'd8;
    e9 = 32'd12;
`else
    e8 = 32'd0;
    e9 = 32'd0;
`endif
    do_reset();
    single("ld_r1", ADDI, 5'd0, 5'd0, 5'd1, 12'd3, 32'd3);
    step(1'b1, ADDI, 5'd1, 5'd0, 5'd7, 12'd1);
    step(1'b1, ADD, 5'd7, 5'd7, 5'd8, 12'd0);
    check("dep0_res", res, 32'd4);
    step(1'b1, ADD, 5'd7, 5'd8, 5'd9, 12'd0);
    check("dep1_res", res, e8);
    check("dep1_rd", 32'(rdout), 32'd8);
    bubble();
    check("dep2_res", res, e9);
    check("dep2_rd", 32'(rdout), 32'd9);
    repeat (2) bubble();
    check("dep_rf9", dut.regs.RF[9], e9);

    step(1'b1, ADDI, 5'd0, 5'd0, 5'd20, 12'd7);
    step(1'b1, ADDI, 5'd0, 5'd0, 5'd21, 12'd9);
    check("fly_res", res, 32'd7);
    rst = 1'b1;
    bubble();
    rst = 1'b0;
    check("mid_rst_v", 32'(valid), 32'd0);
    check("mid_rst_res", res, 32'd0);
    check("mid_rst_rd", 32'(rdout), 32'd0);
    repeat (3) bubble();
    check("mid_rst_rf20", dut.regs.RF[20], 32'd0);
    check("mid_rst_rf21", dut.regs.RF[21], 32'd0);
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut.regs.RF[i];
    check("mid_rst_rf_all", acc, 32'd0);

    single("ld_r1b", ADDI, 5'd0, 5'd0, 5'd1, 12'd3, 32'd3);
    for (int j = 0; j < 8; j++) begin
      if (j % 2 == 0) step(1'b1, ADD, 5'd1, 5'd1, 5'(10 + j), 12'd0);
      else            step(1'b0, ADD, 5'd1, 5'd1, 5'd20, 12'd0);
      if (j > 0) begin
        check("alt_v", 32'(valid), ((j - 1) % 2 == 0) ? 32'd1 : 32'd0);
        if ((j - 1) % 2 == 0) check("alt_res", res, 32'd6);
      end
    end
    bubble();
    check("alt_last_v", 32'(valid), 32'd0);
    repeat (2) bubble();
    check("alt_rf20", dut.regs.RF[20], 32'd0);
    check("alt_rf10", dut.regs.RF[10], 32'd6);
    check("alt_rf16", dut.regs.RF[16], 32'd6);
    check("alt_rf11", dut.regs.RF[11], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
